seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter DIV, default 1000, giving clock cycles per digit slot (legal range 4..65535).
REQ-002 SHALL have parameter GUARD, default 2, giving blanked cycles at the start of each slot (legal range 1..DIV-2).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have optional power pins under USE_POWER_PINS: vccd1 inout 1 (1.8V supply), vssd1 inout 1 (ground).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 enable  input  1  scan-run enable.
REQ-008 blank_lz  input  1  leading-zero blanking enable.
REQ-009 bcd_in  input  16  packed digits {thousands[15:12], hundreds[11:8], tens[7:4], units[3:0]}, matching the 4-digit BCD counter outputs.
REQ-010 seg  output  7  active-high segments {g,f,e,d,c,b,a}.
REQ-011 an  output  4  active-high one-hot digit select; an[0] is units and an[3] is thousands.
REQ-012 frame_start  output  1  one-cycle pulse marking that bcd_in was sampled.

Function
REQ-013 SHALL contain a prescaler that counts 0..DIV-1 and wraps, and a 2-bit slot index that advances 0→1→2→3→0 when the prescaler wraps.
REQ-014 SHALL snapshot bcd_in into a 16-bit frame register on the cycle the slot index moves from 3 to 0, and pulse frame_start in that same cycle.
REQ-015 SHALL keep the displayed digits constant for the whole frame; bcd_in changes mid-frame have no effect until the next snapshot.
REQ-016 SHALL drive an=0 and seg=0 while prescaler < GUARD (anti-ghosting); otherwise an=1<<slot and seg=decode(frame digit[slot]).
REQ-017 SHALL decode 0-9 to standard patterns: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
REQ-018 SHALL decode any nibble 10-15 to a dash (seg=0x40); such digits are never treated as zero for blanking.
REQ-019 SHALL, when blank_lz=1, force seg=0 (an still asserted) for thousands if it is 0, for hundreds if thousands and hundreds are both 0, and for tens if thousands, hundreds and tens are all 0.
REQ-020 SHALL never blank units by the leading-zero rule.
REQ-021 SHALL register seg and an, so they reflect the prescaler and slot state of the previous cycle (1-cycle latency).
REQ-022 SHALL, when enable=0, hold the prescaler, slot index and frame register, suppress frame_start, and drive seg=0 and an=0 from the next cycle.
REQ-023 SHALL, when enable returns to 1, resume from the held prescaler and slot values with no snapshot taken.
REQ-024 SHALL apply blank_lz changes from the next cycle without waiting for a frame boundary.

Reset
REQ-025 SHALL, on reset, set the prescaler to 0, slot to 0, frame register to 0x0000, seg to 0, an to 0 and frame_start to 0.
REQ-026 SHALL give reset priority over enable, and a mid-slot reset SHALL return to slot 0, prescaler 0 on the next cycle.
REQ-027 SHALL take the first snapshot after reset at the first slot 3→0 transition, i.e. 4*DIV enabled cycles after reset release.

Structure
REQ-028 SHALL place the segment pattern constants (digit 0-9, dash, blank) and the slot-index encoding in a shared package, seg7_pkg.
REQ-029 SHALL implement decoding in one combinational sub-module, bcd_to_seg7 (4-bit in, 7-bit out), with leading-zero blanking kept in the parent.

Verification (DIV=8, GUARD=2, enable=1 unless stated)
REQ-030 Reset, then hold bcd_in=0x1234, blank_lz=0 → frame_start at cycle 32; next frame shows an=0001/seg=0x66, then 0010/0x4F, 0100/0x5B, 1000/0x06, with an=0 for the first 2 cycles of each slot.
REQ-031 bcd_in=0x0070, blank_lz=1 → thousands and hundreds seg=0, tens seg=0x07, units seg=0x3F; with blank_lz=0, thousands and hundreds show 0x3F.
REQ-032 bcd_in=0x0000, blank_lz=1 → only units shows 0x3F; bcd_in=0x0A05 → hundreds shows 0x40 and thousands is blanked.
REQ-033 Change bcd_in from 0x1111 to 0x2222 during slot 1 → remainder of the frame shows 0x06 and the next frame shows 0x5B; exactly one frame_start per 32 cycles.
REQ-034 Drop enable for 5 cycles in slot 2 at prescaler=4 → seg=an=0 during the gap, then the slot resumes at prescaler 4 with the same digit.
REQ-035 Assert reset mid-slot 3 → all outputs 0 on the next cycle and the next frame_start occurs 32 cycles after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and digit-slot encoding.
package seg7_pkg;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Slot index; the value doubles as the digit position in the frame
    typedef enum logic [1:0] {
        SLOT_UNITS     = 2'd0,
        SLOT_TENS      = 2'd1,
        SLOT_HUNDREDS  = 2'd2,
        SLOT_THOUSANDS = 2'd3
    } slot_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to seven-segment decoder; non-decimal nibbles show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digit lookup
    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with per-frame snapshot,
// guard blanking at the start of each slot and leading-zero suppression.
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned DIV   = 1000,
    parameter int unsigned GUARD = 2
) (
`ifdef USE_POWER_PINS
    inout  wire         vccd1,
    inout  wire         vssd1,
`endif
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        blank_lz,
    input  logic [15:0] bcd_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam logic [15:0] PRESC_LAST = 16'(DIV - 1);
    localparam logic [15:0] GUARD_CNT  = 16'(GUARD);

    logic [15:0] presc;
    slot_t       slot;
    logic [15:0] frame;
    logic        wrap;
    logic [3:0]  digit;
    logic [3:0]  slot_an;
    logic        lz_blank;
    logic [6:0]  dec_seg;

    assign wrap = (presc == PRESC_LAST);

    // Prescaler, slot index, frame snapshot and frame_start pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            presc       <= '0;
            slot        <= SLOT_UNITS;
            frame       <= '0;
            frame_start <= 1'b0;
        end else if (enable) begin
            frame_start <= wrap && (slot == SLOT_THOUSANDS);
            if (wrap) begin
                presc <= '0;
                slot  <= slot_t'(slot + 2'd1);
                if (slot == SLOT_THOUSANDS)
                    frame <= bcd_in;
            end else begin
                presc <= presc + 16'd1;
            end
        end else begin
            frame_start <= 1'b0;
        end
    end

    // Current digit, anode select and leading-zero suppression for the active slot
    always_comb begin
        digit    = frame[3:0];
        slot_an  = 4'b0001;
        lz_blank = 1'b0;
        case (slot)
            SLOT_UNITS: begin
                digit   = frame[3:0];
                slot_an = 4'b0001;
            end
            SLOT_TENS: begin
                digit    = frame[7:4];
                slot_an  = 4'b0010;
                lz_blank = blank_lz && (frame[15:4] == 12'h000);
            end
            SLOT_HUNDREDS: begin
                digit    = frame[11:8];
                slot_an  = 4'b0100;
                lz_blank = blank_lz && (frame[15:8] == 8'h00);
            end
            SLOT_THOUSANDS: begin
                digit    = frame[15:12];
                slot_an  = 4'b1000;
                lz_blank = blank_lz && (frame[15:12] == 4'h0);
            end
            default: begin
                digit    = frame[3:0];
                slot_an  = 4'b0001;
                lz_blank = 1'b0;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .digit (digit),
        .seg   (dec_seg)
    );

    // Registered display outputs, dark during reset, disable and the guard window
    always_ff @(posedge clk) begin
        if (reset || !enable || (presc < GUARD_CNT)) begin
            seg <= SEG_BLANK;
            an  <= '0;
        end else begin
            an  <= slot_an;
            seg <= lz_blank ? SEG_BLANK : dec_seg;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed testbench for seven_seg_scanner with a scoreboard queue of
// expected outputs produced by a cycle-count reference model.
module tb_seven_seg_scanner;

    localparam int DIVP   = 8;
    localparam int GUARDP = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        blank_lz = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    int nchecks = 0;
    int nerrors = 0;

    // reference model state
    int          m_t = 0;
    logic [15:0] m_frame = 16'h0000;
    logic [11:0] sb_q[$];

    localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                        7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
                                        7'h40, 7'h40, 7'h40, 7'h40};

    seven_seg_scanner #(.DIV(DIVP), .GUARD(GUARDP)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .blank_lz    (blank_lz),
        .bcd_in      (bcd_in),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: push expected outputs from the model, clock, pop and compare
    task automatic tick();
        logic [6:0]  es;
        logic [3:0]  ea;
        logic        ef;
        logic [11:0] e;
        logic [3:0]  d;
        int cnt, sl, lead;
        es = '0; ea = '0; ef = 1'b0;
        if (reset) begin
            m_t = 0;
            m_frame = 16'h0000;
        end else if (enable) begin
            cnt = m_t % DIVP;
            sl  = (m_t / DIVP) % 4;
            if (cnt >= GUARDP) begin
                ea = 4'(1 << sl);
                d  = m_frame[sl*4 +: 4];
                lead = 0;
                for (int i = 3; i >= 1; i--) begin
                    if (m_frame[i*4 +: 4] != 4'h0) break;
                    lead++;
                end
                es = (blank_lz && sl >= 4 - lead) ? 7'h00 : PAT[d];
            end
            if (cnt == DIVP - 1 && sl == 3) begin
                ef = 1'b1;
                m_frame = bcd_in;
            end
            m_t++;
        end
        sb_q.push_back({ef, ea, es});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("seg", 32'(seg), 32'(e[6:0]));
        check("an", 32'(an), 32'(e[10:7]));
        check("frame_start", 32'(frame_start), 32'(e[11]));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Ticks until frame_start is seen (bounded); returns tick count
    task automatic wait_frame(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < 100);
    endtask

    task automatic run_until(input int sl, input int cnt);
        int guard_n;
        guard_n = 0;
        while (!((m_t % DIVP) == cnt && ((m_t / DIVP) % 4) == sl) && guard_n < 100) begin
            tick();
            guard_n++;
        end
        check("run_until_bound", 32'(guard_n < 100), 32'(1));
    endtask

    task automatic expect_out(input string tag, input logic [6:0] s, input logic [3:0] a);
        check({tag, "_seg"}, 32'(seg), 32'(s));
        check({tag, "_an"}, 32'(an), 32'(a));
    endtask

    initial begin
        int n, fs_count;

        // reset state
        reset = 1'b1; bcd_in = 16'h1234; blank_lz = 1'b0; enable = 1'b1;
        ticks(2);
        expect_out("reset", 7'h00, 4'b0000);
        check("reset_fs", 32'(frame_start), 32'(0));

        // first frame after release
        reset = 1'b0;
        wait_frame(n);
        check("first_frame_latency", 32'(n), 32'(32));
        ticks(2);
        expect_out("guard_slot0", 7'h00, 4'b0000);
        tick();
        expect_out("units_1234", 7'h66, 4'b0001);
        ticks(8);
        expect_out("tens_1234", 7'h4F, 4'b0010);
        ticks(8);
        expect_out("hund_1234", 7'h5B, 4'b0100);
        ticks(8);
        expect_out("thou_1234", 7'h06, 4'b1000);
        ticks(5);

        // leading-zero blanking
        bcd_in = 16'h0070; blank_lz = 1'b1;
        ticks(64);
        blank_lz = 1'b0;
        ticks(32);
        bcd_in = 16'h0000; blank_lz = 1'b1;
        ticks(64);
        bcd_in = 16'h0A05;
        ticks(64);

        // blank_lz toggled mid-frame takes effect next cycle
        bcd_in = 16'h0070;
        ticks(40);
        blank_lz = 1'b0;
        ticks(10);
        blank_lz = 1'b1;
        ticks(10);

        // mid-frame bcd_in change; exactly two frame_starts in 64 cycles
        blank_lz = 1'b0; bcd_in = 16'h1111;
        wait_frame(n);
        check("frame_bound_1111", 32'(n < 100), 32'(1));
        run_until(1, 3);
        bcd_in = 16'h2222;
        fs_count = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (frame_start === 1'b1) fs_count++;
        end
        check("fs_per_64", 32'(fs_count), 32'(2));

        // enable gap in slot 2 at prescaler 4
        bcd_in = 16'h1234;
        wait_frame(n);
        check("frame_bound_1234", 32'(n < 100), 32'(1));
        run_until(2, 4);
        enable = 1'b0;
        ticks(5);
        expect_out("gap", 7'h00, 4'b0000);
        enable = 1'b1;
        tick();
        expect_out("resume", 7'h5B, 4'b0100);
        ticks(40);

        // reset mid-slot 3
        run_until(3, 3);
        reset = 1'b1;
        tick();
        expect_out("midreset", 7'h00, 4'b0000);
        reset = 1'b0;
        wait_frame(n);
        check("post_reset_latency", 32'(n), 32'(32));
        ticks(10);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
